// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack op encodings, sequencer states and the
// default stack window used by the stack sequencer.
package cpu_pkg;

  localparam logic [15:0] STACK_BASE_DEF  = 16'h0100;
  localparam logic [15:0] STACK_LIMIT_DEF = 16'h01FF;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } stack_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR1,
    ST_WR2,
    ST_RD1,
    ST_RD2,
    ST_RDW,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/stack_bounds.sv
// Combinational occupancy checks on the stack pointer; SP always points at
// the last written byte, so an empty stack sits one below the base.
module stack_bounds
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              no_room_two,
  output logic              empty,
  output logic              below_two
);

  assign full        = (sp == STACK_LIMIT);
  assign no_room_two = (sp >= (STACK_LIMIT - ADDR_W'(1)));
  assign empty       = (sp == (STACK_BASE - ADDR_W'(1)));
  assign below_two   = (sp < (STACK_BASE + ADDR_W'(1)));

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle stack controller for PUSH/POP/CALL/RET: owns SP, moves one RAM
// byte per cycle and issues the PC redirect plus status clear on CALL/RET.
module stack_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] PushData,
  input  logic [ADDR_W-1:0] ReturnPC,
  input  logic [ADDR_W-1:0] TargetPC,
  input  logic [DATA_W-1:0] RamRData,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamWData,
  output logic              RamWE,
  output logic [ADDR_W-1:0] SP,
  output logic [DATA_W-1:0] PopData,
  output logic [ADDR_W-1:0] PCSet,
  output logic              PCLoad,
  output logic              SregClear,
  output logic              Busy,
  output logic              Done,
  output logic              Fault
);

  seq_state_e        state_q, state_d;
  stack_op_e         op_q, op_d;
  logic [DATA_W-1:0] push_data_q, push_data_d;
  logic [ADDR_W-1:0] return_pc_q, return_pc_d;
  logic [ADDR_W-1:0] target_pc_q, target_pc_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              fault_q, fault_d;
  logic              op_fault_q, op_fault_d;

  logic full, no_room_two, empty, below_two;
  logic bound_fail;

  stack_bounds #(
    .ADDR_W     (ADDR_W),
    .STACK_BASE (STACK_BASE),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_bounds (
    .sp         (sp_q),
    .full       (full),
    .no_room_two(no_room_two),
    .empty      (empty),
    .below_two  (below_two)
  );

  always_comb begin
    bound_fail = 1'b0;
    case (stack_op_e'(Op))
      OP_PUSH: bound_fail = full;
      OP_POP:  bound_fail = empty;
      OP_CALL: bound_fail = no_room_two;
      OP_RET:  bound_fail = below_two;
      default: bound_fail = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    push_data_d = push_data_q;
    return_pc_d = return_pc_q;
    target_pc_d = target_pc_q;
    sp_d        = sp_q;
    pop_data_d  = pop_data_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    fault_d     = fault_q;
    op_fault_d  = op_fault_q;
    RamAddr     = '0;
    RamWData    = '0;
    RamWE       = 1'b0;
    PCSet       = '0;
    PCLoad      = 1'b0;
    SregClear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          op_d        = stack_op_e'(Op);
          push_data_d = PushData;
          return_pc_d = ReturnPC;
          target_pc_d = TargetPC;
          op_fault_d  = bound_fail;
          // A failed bound check skips all RAM traffic and SP movement.
          if (bound_fail) begin
            fault_d = 1'b1;
            state_d = ST_DONE;
          end else if ((stack_op_e'(Op) == OP_PUSH) || (stack_op_e'(Op) == OP_CALL)) begin
            state_d = ST_WR1;
          end else begin
            state_d = ST_RD1;
          end
        end
      end

      ST_WR1: begin
        RamAddr  = sp_q + ADDR_W'(1);
        RamWData = (op_q == OP_CALL) ? return_pc_q[DATA_W-1:0] : push_data_q;
        RamWE    = 1'b1;
        sp_d     = sp_q + ADDR_W'(1);
        state_d  = (op_q == OP_CALL) ? ST_WR2 : ST_DONE;
      end

      ST_WR2: begin
        RamAddr  = sp_q + ADDR_W'(1);
        RamWData = return_pc_q[2*DATA_W-1:DATA_W];
        RamWE    = 1'b1;
        sp_d     = sp_q + ADDR_W'(1);
        state_d  = ST_DONE;
      end

      // POP drops SP as soon as the address is issued; RET keeps SP until
      // both return bytes have been fetched.
      ST_RD1: begin
        RamAddr = sp_q;
        if (op_q == OP_POP) begin
          sp_d    = sp_q - ADDR_W'(1);
          state_d = ST_RDW;
        end else begin
          state_d = ST_RD2;
        end
      end

      ST_RD2: begin
        RamAddr = sp_q - ADDR_W'(1);
        hi_d    = RamRData;
        state_d = ST_RDW;
      end

      ST_RDW: begin
        if (op_q == OP_POP) begin
          pop_data_d = RamRData;
        end else begin
          lo_d = RamRData;
          sp_d = sp_q - ADDR_W'(2);
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (!op_fault_q && ((op_q == OP_CALL) || (op_q == OP_RET))) begin
          PCLoad    = 1'b1;
          SregClear = 1'b1;
          PCSet     = (op_q == OP_CALL) ? target_pc_q : {hi_q, lo_q};
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      push_data_q <= '0;
      return_pc_q <= '0;
      target_pc_q <= '0;
      sp_q        <= STACK_BASE - ADDR_W'(1);
      pop_data_q  <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      fault_q     <= 1'b0;
      op_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      push_data_q <= push_data_d;
      return_pc_q <= return_pc_d;
      target_pc_q <= target_pc_d;
      sp_q        <= sp_d;
      pop_data_q  <= pop_data_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      fault_q     <= fault_d;
      op_fault_q  <= op_fault_d;
    end
  end

  assign SP      = sp_q;
  assign PopData = pop_data_q;
  assign Fault   = fault_q;
  assign Busy    = (state_q != ST_IDLE);
  assign Done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: a small byte RAM model with one-cycle
// read latency, hand-computed expectations per operation.
module tb_stack_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [7:0]  PushData = 8'h00;
  logic [15:0] ReturnPC = 16'h0000;
  logic [15:0] TargetPC = 16'h0000;
  logic [7:0]  RamRData = 8'h00;
  logic [15:0] RamAddr;
  logic [7:0]  RamWData;
  logic        RamWE;
  logic [15:0] SP;
  logic [7:0]  PopData;
  logic [15:0] PCSet;
  logic        PCLoad;
  logic        SregClear;
  logic        Busy;
  logic        Done;
  logic        Fault;

  int vec_count  = 0;
  int miss_count = 0;

  int          r_done, r_busy, r_we, r_pcl, r_sreg;
  logic [15:0] r_pcset, r_addr1, r_addr2;

  logic [7:0] mem [0:65535];

  stack_sequencer dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .PushData (PushData),
    .ReturnPC (ReturnPC),
    .TargetPC (TargetPC),
    .RamRData (RamRData),
    .RamAddr  (RamAddr),
    .RamWData (RamWData),
    .RamWE    (RamWE),
    .SP       (SP),
    .PopData  (PopData),
    .PCSet    (PCSet),
    .PCLoad   (PCLoad),
    .SregClear(SregClear),
    .Busy     (Busy),
    .Done     (Done),
    .Fault    (Fault)
  );

  always #5 Clock = ~Clock;

  // Single-port RAM: synchronous write, read data valid one cycle after address.
  always @(posedge Clock) begin
    if (RamWE) mem[RamAddr] <= RamWData;
    RamRData <= mem[RamAddr];
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetDut;
    Reset = 1'b1;
    Start = 1'b0;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  // Issues one request from IDLE and records what happens until Done.
  // Cycle 1 is the cycle right after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] pd,
                               input logic [15:0] rpc, input logic [15:0] tpc);
    bit finished;
    r_done = 0; r_busy = 0; r_we = 0; r_pcl = 0; r_sreg = 0;
    r_pcset = 16'h0; r_addr1 = 16'h0; r_addr2 = 16'h0;
    finished = 1'b0;
    Op = op; PushData = pd; ReturnPC = rpc; TargetPC = tpc;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 1) r_addr1 = RamAddr;
      if (cyc == 2) r_addr2 = RamAddr;
      if (Busy) r_busy++;
      if (RamWE) r_we++;
      if (SregClear) r_sreg++;
      if (PCLoad) begin
        r_pcl++;
        r_pcset = PCSet;
      end
      if (Done) begin
        r_done   = cyc;
        finished = 1'b1;
        break;
      end
      tick;
    end
    if (!finished) checkOutput("done_timeout", 32'd0, 32'd1);
    tick;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    // Reset state
    resetDut;
    checkOutput("rst_sp", SP, 16'h00FF);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_fault", Fault, 0);
    checkOutput("rst_we", RamWE, 0);
    checkOutput("rst_addr", RamAddr, 0);
    checkOutput("rst_pcload", PCLoad, 0);
    checkOutput("rst_popdata", PopData, 0);

    // PUSH A5 onto the empty stack
    applyStimulus(2'b00, 8'hA5, 16'h0, 16'h0);
    checkOutput("push_done_cyc", r_done, 2);
    checkOutput("push_busy_cyc", r_busy, 2);
    checkOutput("push_we_cyc", r_we, 1);
    checkOutput("push_addr", r_addr1, 16'h0100);
    checkOutput("push_sp", SP, 16'h0100);
    checkOutput("push_mem", mem[16'h0100], 8'hA5);
    checkOutput("push_idle", Busy, 0);

    // POP it back
    applyStimulus(2'b01, 8'h00, 16'h0, 16'h0);
    checkOutput("pop_done_cyc", r_done, 3);
    checkOutput("pop_addr", r_addr1, 16'h0100);
    checkOutput("pop_data", PopData, 8'hA5);
    checkOutput("pop_sp", SP, 16'h00FF);
    checkOutput("pop_we_cyc", r_we, 0);

    // CALL from empty stack
    applyStimulus(2'b10, 8'h00, 16'h1234, 16'h0040);
    checkOutput("call_done_cyc", r_done, 3);
    checkOutput("call_we_cyc", r_we, 2);
    checkOutput("call_pcl_cyc", r_pcl, 1);
    checkOutput("call_sreg_cyc", r_sreg, 1);
    checkOutput("call_pcset", r_pcset, 16'h0040);
    checkOutput("call_mem_lo", mem[16'h0100], 8'h34);
    checkOutput("call_mem_hi", mem[16'h0101], 8'h12);
    checkOutput("call_sp", SP, 16'h0101);

    // RET back
    applyStimulus(2'b11, 8'h00, 16'h0, 16'h0);
    checkOutput("ret_done_cyc", r_done, 4);
    checkOutput("ret_addr1", r_addr1, 16'h0101);
    checkOutput("ret_addr2", r_addr2, 16'h0100);
    checkOutput("ret_pcl_cyc", r_pcl, 1);
    checkOutput("ret_sreg_cyc", r_sreg, 1);
    checkOutput("ret_pcset", r_pcset, 16'h1234);
    checkOutput("ret_sp", SP, 16'h00FF);
    checkOutput("ret_we_cyc", r_we, 0);
    checkOutput("ret_fault", Fault, 0);

    // POP on empty stack faults and stays sticky
    applyStimulus(2'b01, 8'h00, 16'h0, 16'h0);
    checkOutput("uflow_done_cyc", r_done, 1);
    checkOutput("uflow_fault", Fault, 1);
    checkOutput("uflow_sp", SP, 16'h00FF);
    checkOutput("uflow_we_cyc", r_we, 0);
    applyStimulus(2'b00, 8'h3C, 16'h0, 16'h0);
    checkOutput("sticky_push_sp", SP, 16'h0100);
    checkOutput("sticky_push_mem", mem[16'h0100], 8'h3C);
    checkOutput("sticky_fault", Fault, 1);

    // RET with a single byte on the stack underflows
    applyStimulus(2'b11, 8'h00, 16'h0, 16'h0);
    checkOutput("ret_uflow_done_cyc", r_done, 1);
    checkOutput("ret_uflow_pcl", r_pcl, 0);
    checkOutput("ret_uflow_sp", SP, 16'h0100);

    // Fill the stack to the limit, then PUSH overflows
    resetDut;
    for (int i = 0; i < 256; i++) applyStimulus(2'b00, 8'(i) ^ 8'h5A, 16'h0, 16'h0);
    checkOutput("fill_sp", SP, 16'h01FF);
    checkOutput("fill_fault", Fault, 0);
    applyStimulus(2'b00, 8'h77, 16'h0, 16'h0);
    checkOutput("oflow_done_cyc", r_done, 1);
    checkOutput("oflow_we_cyc", r_we, 0);
    checkOutput("oflow_fault", Fault, 1);
    checkOutput("oflow_sp", SP, 16'h01FF);
    checkOutput("oflow_mem", mem[16'h01FF], 8'hA5);

    // CALL at SP=01FD fits exactly; CALL at SP=01FE does not
    resetDut;
    for (int i = 0; i < 254; i++) applyStimulus(2'b00, 8'(i), 16'h0, 16'h0);
    checkOutput("edge_sp", SP, 16'h01FD);
    applyStimulus(2'b10, 8'h00, 16'hBEEF, 16'h0200);
    checkOutput("edge_call_pcl", r_pcl, 1);
    checkOutput("edge_call_pcset", r_pcset, 16'h0200);
    checkOutput("edge_call_sp", SP, 16'h01FF);
    checkOutput("edge_call_fault", Fault, 0);
    applyStimulus(2'b01, 8'h00, 16'h0, 16'h0);
    checkOutput("edge_pop_data", PopData, 8'hBE);
    checkOutput("edge_pop_sp", SP, 16'h01FE);
    applyStimulus(2'b10, 8'h00, 16'h5555, 16'h0300);
    checkOutput("call_oflow_done_cyc", r_done, 1);
    checkOutput("call_oflow_pcl", r_pcl, 0);
    checkOutput("call_oflow_sreg", r_sreg, 0);
    checkOutput("call_oflow_we", r_we, 0);
    checkOutput("call_oflow_fault", Fault, 1);
    checkOutput("call_oflow_sp", SP, 16'h01FE);

    // Start held high: one PUSH per IDLE visit, then Reset mid-write
    resetDut;
    Op = 2'b00; PushData = 8'h11; Start = 1'b1;
    tick;
    checkOutput("hold_wr1_we", RamWE, 1);
    checkOutput("hold_wr1_addr", RamAddr, 16'h0100);
    tick;
    checkOutput("hold_done", Done, 1);
    checkOutput("hold_done_we", RamWE, 0);
    checkOutput("hold_done_sp", SP, 16'h0100);
    tick;
    checkOutput("hold_idle_busy", Busy, 0);
    tick;
    checkOutput("hold_wr1b_we", RamWE, 1);
    checkOutput("hold_wr1b_addr", RamAddr, 16'h0101);
    Reset = 1'b1;
    Start = 1'b0;
    tick;
    checkOutput("midrst_sp", SP, 16'h00FF);
    checkOutput("midrst_busy", Busy, 0);
    checkOutput("midrst_we", RamWE, 0);
    Reset = 1'b0;
    tick;
    checkOutput("midrst_idle", Busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
